// File: rtl/mpu_spi_responder.sv
// SPI mode-3 slave emulating the MPU9250 register interface: a 128 x 8 register file
// with auto-increment bursts, a fixed WHO_AM_I identity, and a host-side preload/observe port.
module mpu_spi_responder #(
  parameter logic [6:0] WHO_AM_I_ADDR = 7'h75,
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h71,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_SS_g,
  input  logic       SPI_CK_g,
  input  logic       SPI_DO_g,
  output logic       SPI_DI_g,
  input  logic       host_wr,
  input  logic [6:0] host_addr,
  input  logic [7:0] host_wr_data,
  output logic [7:0] host_rd_data,
  output logic       spi_wr_strobe,
  output logic [6:0] spi_wr_addr,
  output logic [7:0] spi_wr_data,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD,
    ST_WR
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic [SYNC_STAGES:0]   ss_valid;
  logic                   sck_hist, ss_hist;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_fall, ss_rise;

  logic [7:0] regs [128];
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, rx_byte;
  logic [7:0] tx_shift;
  logic [6:0] addr_ptr;
  logic       miso_q;
  logic [7:0] addr_rd_val, next_rd_val;
  logic       last_bit, wr_commit;

  logic start_frame, abort, addr_done, rd_done, wr_done, rd_shift, bit_step;

  function automatic logic [7:0] reg_read(input logic [6:0] a);
    return (a == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : regs[a];
  endfunction

  // ss_valid marks which pipeline stages hold real post-reset samples, so an SS that is
  // already low when reset releases is never mistaken for a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_hist  <= 1'b1;
      ss_hist   <= 1'b1;
      ss_valid  <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_CK_g};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SPI_SS_g};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_DO_g};
      sck_hist  <= sck_s;
      ss_hist   <= ss_s;
      ss_valid  <= {ss_valid[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  assign ss_fall  = ss_valid[SYNC_STAGES] & ss_hist & ~ss_s;
  assign ss_rise  = ss_s & ~ss_hist;
  assign active   = ~ss_s;

  assign rx_byte      = {rx_shift[6:0], mosi_s};
  assign last_bit     = (bit_cnt == 3'd7);
  assign addr_rd_val  = reg_read(rx_byte[6:0]);
  assign next_rd_val  = reg_read(addr_ptr + 7'd1);
  assign wr_commit    = wr_done && (addr_ptr != WHO_AM_I_ADDR);
  assign host_rd_data = reg_read(host_addr);
  assign SPI_DI_g     = miso_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bit 7 of a read byte is already on MISO from the previous byte boundary, so the
  // first falling edge of each byte (bit_cnt == 0) must hold it rather than shift.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    abort       = 1'b0;
    addr_done   = 1'b0;
    rd_done     = 1'b0;
    wr_done     = 1'b0;
    rd_shift    = 1'b0;
    bit_step    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          next_state  = ST_ADDR;
          start_frame = 1'b1;
        end
      end
      ST_ADDR: begin
        if (sck_rise) begin
          bit_step = 1'b1;
          if (last_bit) begin
            addr_done  = 1'b1;
            next_state = rx_byte[7] ? ST_RD : ST_WR;
          end
        end
      end
      ST_RD: begin
        if (sck_rise) begin
          bit_step = 1'b1;
          rd_done  = last_bit;
        end else if (sck_fall && bit_cnt != 3'd0) begin
          rd_shift = 1'b1;
        end
      end
      ST_WR: begin
        if (sck_rise) begin
          bit_step = 1'b1;
          wr_done  = last_bit;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (state != ST_IDLE && ss_rise) begin
      next_state = ST_IDLE;
      abort      = 1'b1;
      addr_done  = 1'b0;
      rd_done    = 1'b0;
      wr_done    = 1'b0;
      rd_shift   = 1'b0;
      bit_step   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      addr_ptr      <= '0;
      miso_q        <= 1'b0;
      spi_wr_strobe <= 1'b0;
      spi_wr_addr   <= '0;
      spi_wr_data   <= '0;
    end else begin
      spi_wr_strobe <= 1'b0;
      if (start_frame || abort) begin
        bit_cnt <= '0;
      end else if (bit_step) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (bit_step) begin
        rx_shift <= rx_byte;
      end
      if (abort) begin
        miso_q <= 1'b0;
      end
      if (addr_done) begin
        addr_ptr <= rx_byte[6:0];
        if (rx_byte[7]) begin
          tx_shift <= addr_rd_val;
          miso_q   <= addr_rd_val[7];
        end
      end
      if (rd_shift) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        miso_q   <= tx_shift[6];
      end
      if (rd_done) begin
        addr_ptr <= addr_ptr + 7'd1;
        tx_shift <= next_rd_val;
        miso_q   <= next_rd_val[7];
      end
      if (wr_done) begin
        addr_ptr <= addr_ptr + 7'd1;
      end
      if (wr_commit) begin
        spi_wr_strobe <= 1'b1;
        spi_wr_addr   <= addr_ptr;
        spi_wr_data   <= rx_byte;
      end
    end
  end

  // The SPI assignment comes last so it wins a same-cycle, same-address host write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (host_wr && host_addr != WHO_AM_I_ADDR) begin
        regs[host_addr] <= host_wr_data;
      end
      if (wr_commit) begin
        regs[addr_ptr] <= rx_byte;
      end
    end
  end

endmodule

// File: doc/mpu_spi_responder.md
# mpu_spi_responder

SPI slave that emulates the MPU9250 register interface: 128 × 8-bit register file, write/read framing with auto-increment, WHO_AM_I identity register. Sits opposite the SPI master, either in the simulation bench as a stand-in MPU9250 or in fabric for loopback self-test. A host port lets the fabric preload sensor values and observe SPI writes.

## Interface
- WHO_AM_I_ADDR, 7'h75, read-only identity register address
- WHO_AM_I_VAL, 8'h71, value returned at WHO_AM_I_ADDR
- SYNC_STAGES, 2, synchronizer depth on SPI inputs (≥2)
- clk  in  1  system clock; must be ≥8× SCK frequency
- rst  in  1  reset, asynchronous, active-low
- SPI_SS_g  in  1  slave select from master, active-low
- SPI_CK_g  in  1  SCK from master; SPI mode 3, idles high
- SPI_DO_g  in  1  MOSI, master out
- SPI_DI_g  out  1  MISO, slave out
- host_wr  in  1  host write strobe
- host_addr  in  7  host write/read address
- host_wr_data  in  8  host write data
- host_rd_data  out  8  combinational read of reg[host_addr]
- spi_wr_strobe  out  1  one-cycle pulse when an SPI write commits
- spi_wr_addr  out  7  address of committed write, held until next commit
- spi_wr_data  out  8  data of committed write, held until next commit
- active  out  1  synchronized SS asserted (transfer in progress)

## Operation
- SCK, SS, MOSI each pass SYNC_STAGES flops plus one history flop; rise/fall edges detected on synchronized SCK.
- Frame: byte 0 = {R/W, addr[6:0]}, MSB first; R/W=1 read, 0 write. Following bytes are data.
- Bits sampled on SCK rising edge, MISO updated on SCK falling edge.
- FSM: IDLE → ADDR on synchronized SS falling; ADDR → RD or WR after 8th rising edge; any state → IDLE on synchronized SS rising.
- ADDR: shift in 8 bits, 3-bit counter. On 8th bit latch rw and addr_ptr; for read load tx_shift = reg[addr_ptr] and drive bit 7 on MISO in the same cycle.
- RD: each falling edge shifts tx_shift left, MISO = new bit 7. After 8th rising edge of each data byte: addr_ptr+1, reload tx_shift from reg[addr_ptr+1]; bit 7 driven immediately.
- WR: shift in 8 bits; after 8th rising edge write reg[addr_ptr], pulse spi_wr_strobe, update spi_wr_addr/data, addr_ptr+1.
- addr_ptr increments modulo 128 (7'h7F → 7'h00).
- WHO_AM_I_ADDR always reads WHO_AM_I_VAL. SPI and host writes there are discarded; no spi_wr_strobe.
- SS deasserted mid-byte: partial byte discarded, no write, no strobe, bit counter cleared.
- MISO = 0 whenever not in RD.
- Host write and SPI commit to same address in same cycle: SPI data wins. Different addresses: both take effect.
- host_rd_data reflects writes the cycle after commit.

## Timing
- Reset values: all regs 0 except WHO_AM_I; SPI_DI_g=0, spi_wr_strobe=0, spi_wr_addr=0, spi_wr_data=0, active=0, FSM IDLE.
- Input-to-detect latency: SYNC_STAGES+1 clk cycles after pin edge.
- MISO update: 1 clk after falling-edge detect, i.e. SYNC_STAGES+2 cycles after the pin edge. Must settle before the next rising edge. Hence the ≥8× ratio (100 MHz / 1 MHz has wide margin).
- spi_wr_strobe: exactly one cycle, 1 clk after the 8th rising-edge detect of a data byte.
- Reset asserted mid-transfer: immediate return to reset values. After release, stays IDLE until a new SS falling edge is seen; an SS already low at release does not start a frame.

## Test plan
- Read 0x75 (byte 0 = 0xF5) → MISO returns 0x71; no strobe.
- Write 0x6B ← 0x80 → spi_wr_strobe once, spi_wr_addr=0x6B, spi_wr_data=0x80. Then read 0x6B → 0x80; host_rd_data at 0x6B = 0x80.
- Burst write at 0x7E of 0x11, 0x22, 0x33 → reg 0x7E=0x11, 0x7F=0x22, 0x00=0x33; three strobes.
- Host preloads 0x3B..0x40 with 0xA0..0xA5, then SPI burst read from 0x3B for 6 bytes → 0xA0..0xA5 in order.
- SS raised after 4 data bits of a write to 0x10 → reg 0x10 unchanged, no strobe. Next full transfer is correct.
- rst low during byte 1 of a write → all outputs at reset values, reg contents cleared. Next frame decodes normally. Same-cycle host/SPI write to 0x20 → SPI value retained.
